// File: rtl/door_sprite_anim.sv
// door_sprite_anim: per-door lock/unlock sprite animation plus the registered door pixel address/hit.
// Optional DOOR_AUTOLOCK_EN: an open door auto-closes after AUTOLOCK_TICKS frame ticks.
module door_sprite_anim #(
  parameter int unsigned NUM_DOORS    = 2,
  parameter int unsigned ACTIVE_STATE = 2,
  parameter int unsigned X0           = 260,
  parameter int unsigned X_STEP       = 24,
  parameter int unsigned Y0           = 120,
  parameter int unsigned SPR_W        = 20,
  parameter int unsigned SPR_H        = 20,
  parameter int unsigned SHEET_W      = 320,
  parameter int unsigned SHEET_X0     = 120,
  parameter int unsigned SHEET_Y0     = 40,
  parameter int unsigned FRAMES       = 4,
  parameter int unsigned FRAME_TICKS  = 4
`ifdef DOOR_AUTOLOCK_EN
  ,parameter int unsigned AUTOLOCK_TICKS = 240
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           state,
  input  logic [9:0]           h_cnt,
  input  logic [9:0]           v_cnt,
  input  logic                 frame_tick,
  input  logic [NUM_DOORS-1:0] unlock_req,
  input  logic [NUM_DOORS-1:0] lock_req,
  output logic [16:0]          pixel_addr,
  output logic                 isObject,
  output logic [NUM_DOORS-1:0] door_open,
  output logic                 anim_busy
);

  localparam int unsigned FW       = $clog2(FRAMES);
  localparam int unsigned TW       = $clog2(FRAME_TICKS + 1);
  localparam int unsigned AW       = 20;
  localparam int unsigned ADDR_MOD = 76800;
  localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES - 1);
`ifdef DOOR_AUTOLOCK_EN
  localparam int unsigned DW       = $clog2(AUTOLOCK_TICKS + 1);
`endif

  typedef enum logic [1:0] {LOCKED, OPENING, OPEN, CLOSING} door_state_e;

  door_state_e           st_q    [NUM_DOORS];
  door_state_e           st_d    [NUM_DOORS];
  logic [FW-1:0]         frame_q [NUM_DOORS];
  logic [FW-1:0]         frame_d [NUM_DOORS];
  logic [TW-1:0]         tick_q  [NUM_DOORS];
  logic [TW-1:0]         tick_d  [NUM_DOORS];
`ifdef DOOR_AUTOLOCK_EN
  logic [DW-1:0]         dwell_q [NUM_DOORS];
  logic [DW-1:0]         dwell_d [NUM_DOORS];
`endif
  logic [FW-1:0]         frame_inc [NUM_DOORS];
  logic [FW-1:0]         frame_dec [NUM_DOORS];
  logic [NUM_DOORS-1:0]  step;
  logic [NUM_DOORS-1:0]  unl;
  logic [NUM_DOORS-1:0]  lck;

  logic [16:0]           pixel_addr_q, pixel_addr_d;
  logic                  is_object_q, is_object_d;
  logic [NUM_DOORS-1:0]  door_open_q, door_open_d;
  logic                  anim_busy_q, anim_busy_d;

  logic                  active;
  logic [8:0]            x;
  logic [8:0]            y;
  logic                  unused_lsb;

  assign active     = (state == 4'(ACTIVE_STATE));
  assign x          = h_cnt[9:1];
  assign y          = v_cnt[9:1];
  assign unused_lsb = h_cnt[0] ^ v_cnt[0];

  // Conflicting lock+unlock in one cycle cancel out.
  assign unl = unlock_req & ~lock_req;
  assign lck = lock_req & ~unlock_req;

  // Per-door step strobe and saturating frame neighbours.
  always_comb begin
    for (int unsigned i = 0; i < NUM_DOORS; i++) begin
      step[i]      = frame_tick && (tick_q[i] == TW'(FRAME_TICKS - 1));
      frame_inc[i] = (frame_q[i] == LAST_FRAME) ? LAST_FRAME : frame_q[i] + FW'(1);
      frame_dec[i] = (frame_q[i] == '0) ? '0 : frame_q[i] - FW'(1);
    end
  end

  // Door FSMs next-state, plus registered status flags derived from next state.
  always_comb begin
    anim_busy_d = 1'b0;
    door_open_d = '0;
    for (int unsigned i = 0; i < NUM_DOORS; i++) begin
      st_d[i]    = st_q[i];
      frame_d[i] = frame_q[i];
      tick_d[i]  = tick_q[i];
`ifdef DOOR_AUTOLOCK_EN
      dwell_d[i] = dwell_q[i];
`endif
      if (!active) begin
        st_d[i]    = LOCKED;
        frame_d[i] = '0;
        tick_d[i]  = '0;
      end else begin
        case (st_q[i])
          LOCKED: begin
            if (unl[i]) begin
              st_d[i]   = OPENING;
              tick_d[i] = '0;
            end
          end
          OPENING: begin
            if (lck[i]) begin
              st_d[i]   = CLOSING;
              tick_d[i] = '0;
            end else if (step[i]) begin
              tick_d[i]  = '0;
              frame_d[i] = frame_inc[i];
              if (frame_inc[i] == LAST_FRAME) st_d[i] = OPEN;
            end else if (frame_tick) begin
              tick_d[i] = tick_q[i] + TW'(1);
            end
          end
          OPEN: begin
            frame_d[i] = LAST_FRAME;
            if (lck[i]) begin
              st_d[i]   = CLOSING;
              tick_d[i] = '0;
            end
`ifdef DOOR_AUTOLOCK_EN
            else if (unl[i]) begin
              dwell_d[i] = '0;
            end else if (frame_tick) begin
              if (dwell_q[i] == DW'(AUTOLOCK_TICKS - 1)) begin
                st_d[i]   = CLOSING;
                tick_d[i] = '0;
              end else begin
                dwell_d[i] = dwell_q[i] + DW'(1);
              end
            end
`endif
          end
          CLOSING: begin
            if (unl[i]) begin
              st_d[i]   = OPENING;
              tick_d[i] = '0;
            end else if (step[i]) begin
              tick_d[i]  = '0;
              frame_d[i] = frame_dec[i];
              if (frame_dec[i] == '0) st_d[i] = LOCKED;
            end else if (frame_tick) begin
              tick_d[i] = tick_q[i] + TW'(1);
            end
          end
          default: begin
            st_d[i]    = LOCKED;
            frame_d[i] = '0;
            tick_d[i]  = '0;
          end
        endcase
      end
`ifdef DOOR_AUTOLOCK_EN
      // Dwell only runs while staying in OPEN, so it is zero on entry.
      if (st_q[i] != OPEN || st_d[i] != OPEN) dwell_d[i] = '0;
`endif
      door_open_d[i] = (st_d[i] == OPEN);
      anim_busy_d    = anim_busy_d | (st_d[i] == OPENING) | (st_d[i] == CLOSING);
    end
  end

  // Hit test and sprite-sheet address; lowest door index wins, misses hold the address.
  always_comb begin
    logic [AW-1:0] dx;
    logic [AW-1:0] sx;
    logic [AW-1:0] sy;
    logic [AW-1:0] lin;
    dx           = '0;
    sx           = '0;
    sy           = '0;
    lin          = '0;
    is_object_d  = 1'b0;
    pixel_addr_d = pixel_addr_q;
    for (int unsigned i = 0; i < NUM_DOORS; i++) begin
      dx = AW'(X0 + i * X_STEP);
      if (active && !is_object_d &&
          AW'(x) >= dx && AW'(x) < dx + AW'(SPR_W) &&
          AW'(y) >= AW'(Y0) && AW'(y) < AW'(Y0 + SPR_H)) begin
        is_object_d  = 1'b1;
        sx           = AW'(SHEET_X0) + AW'(frame_q[i]) * AW'(SPR_W) + (AW'(x) - dx);
        sy           = AW'(SHEET_Y0) + (AW'(y) - AW'(Y0));
        lin          = (sx + sy * AW'(SHEET_W)) % AW'(ADDR_MOD);
        pixel_addr_d = 17'(lin);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DOORS; i++) begin
        st_q[i]    <= LOCKED;
        frame_q[i] <= '0;
        tick_q[i]  <= '0;
`ifdef DOOR_AUTOLOCK_EN
        dwell_q[i] <= '0;
`endif
      end
      pixel_addr_q <= '0;
      is_object_q  <= 1'b0;
      door_open_q  <= '0;
      anim_busy_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_DOORS; i++) begin
        st_q[i]    <= st_d[i];
        frame_q[i] <= frame_d[i];
        tick_q[i]  <= tick_d[i];
`ifdef DOOR_AUTOLOCK_EN
        dwell_q[i] <= dwell_d[i];
`endif
      end
      pixel_addr_q <= pixel_addr_d;
      is_object_q  <= is_object_d;
      door_open_q  <= door_open_d;
      anim_busy_q  <= anim_busy_d;
    end
  end

  assign pixel_addr = pixel_addr_q;
  assign isObject   = is_object_q;
  assign door_open  = door_open_q;
  assign anim_busy  = anim_busy_q;

endmodule

// File: tb/tb_door_sprite_anim.sv
// Self-checking bench for door_sprite_anim: pixel expectations queued at drive time, popped one clk later.
module tb_door_sprite_anim;

  localparam int ND = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    state;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          frame_tick;
  logic [ND-1:0] unlock_req;
  logic [ND-1:0] lock_req;
  logic [16:0]   pixel_addr;
  logic          isObject;
  logic [ND-1:0] door_open;
  logic          anim_busy;

  typedef struct {
    bit          obj;
    logic [16:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          exp_fr [ND];
  bit          model_active;
  logic [16:0] model_addr;

  door_sprite_anim dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .frame_tick (frame_tick),
    .unlock_req (unlock_req),
    .lock_req   (lock_req),
    .pixel_addr (pixel_addr),
    .isObject   (isObject),
    .door_open  (door_open),
    .anim_busy  (anim_busy)
  );

  always #5 clk = ~clk;

  // Drive a pixel coordinate and queue what the door geometry says it should produce.
  task automatic drive_pixel(input int h, input int v);
    exp_t e;
    int   x, y, dx;
    bit   found;
    h_cnt  = 10'(h);
    v_cnt  = 10'(v);
    x      = h / 2;
    y      = v / 2;
    found  = 1'b0;
    e.obj  = 1'b0;
    e.addr = model_addr;
    if (model_active) begin
      for (int d = 0; d < ND; d++) begin
        dx = 260 + d * 24;
        if (!found && x >= dx && x < dx + 20 && y >= 120 && y < 140) begin
          found  = 1'b1;
          e.obj  = 1'b1;
          e.addr = 17'((120 + exp_fr[d] * 20 + (x - dx) + (40 + (y - 120)) * 320) % 76800);
        end
      end
    end
    model_addr = e.addr;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic [ND-1:0] unl, input logic [ND-1:0] lck, input bit with_tick);
    unlock_req = unl;
    lock_req   = lck;
    frame_tick = with_tick;
    @(negedge clk);
    unlock_req = '0;
    lock_req   = '0;
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; state = 4'd0; h_cnt = '0; v_cnt = '0;
    frame_tick = 1'b0; unlock_req = '0; lock_req = '0;
    repeat (2) @(negedge clk);
    checks++; if (pixel_addr !== 17'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", pixel_addr); end
    checks++; if (isObject !== 1'b0) begin errors++; $display("FAIL reset_obj got %0b exp 0", isObject); end
    checks++; if (door_open !== 2'b00) begin errors++; $display("FAIL reset_open got %b exp 00", door_open); end
    checks++; if (anim_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", anim_busy); end
    rst = 1'b0; state = 4'd2; model_active = 1'b1; model_addr = '0; exp_fr = '{0, 0};
    @(negedge clk);
  endtask

  task automatic test_hit_locked();
    int   hs [11] = '{520, 568, 600, 518, 558, 560, 520, 520, 520, 606, 608};
    int   vs [11] = '{240, 240, 300, 240, 240, 240, 239, 278, 280, 240, 240};
    exp_t e;
    for (int k = 0; k < 11; k++) begin
      drive_pixel(hs[k], vs[k]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({isObject, pixel_addr} !== {e.obj, e.addr}) begin
        errors++;
        $display("FAIL hit_locked[%0d] obj/addr got %0b/%0d exp %0b/%0d", k, isObject, pixel_addr, e.obj, e.addr);
      end
    end
  endtask

  task automatic test_open_seq();
    exp_t e;
    pulse(2'b01, 2'b00, 1'b0);
    checks++; if (anim_busy !== 1'b1) begin errors++; $display("FAIL open_start_busy got %0b exp 1", anim_busy); end
    for (int t = 1; t <= 12; t++) begin
      tick(1);
      exp_fr[0] = t / 4;
      drive_pixel(520, 240);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({isObject, pixel_addr} !== {e.obj, e.addr}) begin
        errors++;
        $display("FAIL open_addr[t=%0d] obj/addr got %0b/%0d exp %0b/%0d", t, isObject, pixel_addr, e.obj, e.addr);
      end
      checks++;
      if (anim_busy !== (t < 12)) begin errors++; $display("FAIL open_busy[t=%0d] got %0b exp %0b", t, anim_busy, t < 12); end
      checks++;
      if (door_open !== ((t == 12) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL open_flag[t=%0d] got %b exp %b", t, door_open, (t == 12) ? 2'b01 : 2'b00);
      end
    end
    pulse(2'b01, 2'b00, 1'b0);
    @(negedge clk);
    checks++;
    if ({door_open, anim_busy} !== 3'b010) begin
      errors++; $display("FAIL open_ignore_unlock open/busy got %b/%0b exp 01/0", door_open, anim_busy);
    end
  endtask

  task automatic test_close();
    exp_t e;
    int   steps [3] = '{3, 1, 4};
    int   frs   [3] = '{2, 1, 0};
    pulse(2'b00, 2'b01, 1'b0);
    checks++;
    if ({door_open, anim_busy} !== 3'b001) begin
      errors++; $display("FAIL close_start open/busy got %b/%0b exp 00/1", door_open, anim_busy);
    end
    for (int t = 1; t <= 12; t++) begin
      tick(1);
      exp_fr[0] = 3 - t / 4;
      drive_pixel(520, 240);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({isObject, pixel_addr, anim_busy} !== {e.obj, e.addr, t < 12}) begin
        errors++;
        $display("FAIL close_full[t=%0d] obj/addr/busy got %0b/%0d/%0b exp %0b/%0d/%0b",
                 t, isObject, pixel_addr, anim_busy, e.obj, e.addr, t < 12);
      end
    end
    // Re-open to frame 2 with a partial tick count, then lock coincident with a tick.
    pulse(2'b01, 2'b00, 1'b0);
    tick(10);
    pulse(2'b00, 2'b01, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(steps[k]);
      exp_fr[0] = frs[k];
      drive_pixel(520, 240);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({isObject, pixel_addr} !== {e.obj, e.addr}) begin
        errors++;
        $display("FAIL reverse_close[%0d] obj/addr got %0b/%0d exp %0b/%0d", k, isObject, pixel_addr, e.obj, e.addr);
      end
    end
    checks++;
    if ({door_open, anim_busy} !== 3'b000) begin
      errors++; $display("FAIL reverse_locked open/busy got %b/%0b exp 00/0", door_open, anim_busy);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    pulse(2'b01, 2'b01, 1'b0);
    checks++; if (anim_busy !== 1'b0) begin errors++; $display("FAIL simul_busy got %0b exp 0", anim_busy); end
    tick(4);
    drive_pixel(520, 240);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if ({isObject, pixel_addr} !== {e.obj, e.addr}) begin
      errors++; $display("FAIL simul_frame obj/addr got %0b/%0d exp %0b/%0d", isObject, pixel_addr, e.obj, e.addr);
    end
  endtask

  task automatic test_inactive();
    exp_t e;
    pulse(2'b10, 2'b00, 1'b0);
    tick(5);
    exp_fr[1] = 1;
    drive_pixel(568, 240);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if ({isObject, pixel_addr} !== {e.obj, e.addr}) begin
      errors++; $display("FAIL inact_pre obj/addr got %0b/%0d exp %0b/%0d", isObject, pixel_addr, e.obj, e.addr);
    end
    state = 4'd3; model_active = 1'b0; exp_fr[1] = 0;
    drive_pixel(568, 240);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if ({isObject, pixel_addr, anim_busy} !== {e.obj, e.addr, 1'b0}) begin
      errors++;
      $display("FAIL inact_forced obj/addr/busy got %0b/%0d/%0b exp %0b/%0d/0", isObject, pixel_addr, anim_busy, e.obj, e.addr);
    end
    pulse(2'b11, 2'b00, 1'b0);
    @(negedge clk);
    checks++; if (anim_busy !== 1'b0) begin errors++; $display("FAIL inact_req_ignored busy got %0b exp 0", anim_busy); end
    state = 4'd2; model_active = 1'b1;
    drive_pixel(568, 240);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if ({isObject, pixel_addr, anim_busy} !== {e.obj, e.addr, 1'b0}) begin
      errors++;
      $display("FAIL inact_return obj/addr/busy got %0b/%0d/%0b exp %0b/%0d/0", isObject, pixel_addr, anim_busy, e.obj, e.addr);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    pulse(2'b01, 2'b00, 1'b0);
    tick(2);
    drive_pixel(540, 250);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if ({isObject, pixel_addr, anim_busy} !== {e.obj, e.addr, 1'b1}) begin
      errors++;
      $display("FAIL areset_pre obj/addr/busy got %0b/%0d/%0b exp %0b/%0d/1", isObject, pixel_addr, anim_busy, e.obj, e.addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pixel_addr, isObject, door_open, anim_busy} !== 21'd0) begin
      errors++;
      $display("FAIL areset_now addr/obj/open/busy got %0d/%0b/%b/%0b exp 0/0/00/0", pixel_addr, isObject, door_open, anim_busy);
    end
    @(negedge clk);
    rst = 1'b0; model_addr = '0; exp_fr = '{0, 0};
    drive_pixel(600, 300);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if ({isObject, pixel_addr} !== {e.obj, e.addr}) begin
      errors++; $display("FAIL areset_miss obj/addr got %0b/%0d exp %0b/%0d", isObject, pixel_addr, e.obj, e.addr);
    end
    tick(4);
    drive_pixel(520, 240);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if ({isObject, pixel_addr, anim_busy} !== {e.obj, e.addr, 1'b0}) begin
      errors++;
      $display("FAIL areset_locked obj/addr/busy got %0b/%0d/%0b exp %0b/%0d/0", isObject, pixel_addr, anim_busy, e.obj, e.addr);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 50; k++) begin
      drive_pixel(514 + 2 * k, 240 + (k % 3) * 8);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({isObject, pixel_addr} !== {e.obj, e.addr}) begin
        errors++;
        $display("FAIL b2b[%0d] obj/addr got %0b/%0d exp %0b/%0d", k, isObject, pixel_addr, e.obj, e.addr);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hit_locked();
    test_open_seq();
    test_close();
    test_simultaneous();
    test_inactive();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
